// File: rtl/kuyruk_pkg.sv
// kuyruk_pkg: head FSM states and {count,data} entry field helpers for the timed queue
package kuyruk_pkg;
  typedef enum logic [1:0] {BOS, SAYIYOR, HAZIR} durum_t;
  function automatic int sayac_lsb(input int data_w);
    return data_w;
  endfunction
  function automatic int giris_w(input int cnt_w, input int data_w);
    return cnt_w + data_w;
  endfunction
endpackage

// File: rtl/kuyruk_bellek.sv
// kuyruk_bellek: circular {count,data} storage with occupancy; bulk load when KUYRUK_YUKLE_EN is defined
module kuyruk_bellek import kuyruk_pkg::*; #(
  parameter int DATA_W = 5,
  parameter int CNT_W = 3,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic yaz,
  input  logic oku,
  input  logic [giris_w(CNT_W, DATA_W)-1:0] yaz_veri,
  output logic [DATA_W-1:0] bas_veri,
  output logic [CNT_W-1:0] sonraki_sayac,
  output logic [$clog2(DEPTH):0] seviye,
  output logic dolu,
  output logic bos
`ifdef KUYRUK_YUKLE_EN
  ,input logic yukle,
  input  logic [DEPTH*giris_w(CNT_W, DATA_W)-1:0] yukle_veri,
  input  logic [$clog2(DEPTH):0] yukle_sayisi
`endif
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ENTRY_W = giris_w(CNT_W, DATA_W);
  localparam int CNT_LSB = sayac_lsb(DATA_W);
  localparam logic [ADDR_W:0] TAM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] BIR = (ADDR_W+1)'(1);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W:0] wr, rd;
  logic [ENTRY_W-1:0] bas, sonraki;
  assign bas = mem[rd[ADDR_W-1:0]];
  assign sonraki = mem[rd[ADDR_W-1:0] + ADDR_W'(1)];
  assign bas_veri = bas[DATA_W-1:0];
  assign sonraki_sayac = sonraki[CNT_LSB +: CNT_W];
  assign seviye = wr - rd;
  assign dolu = seviye == TAM;
  assign bos = seviye == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end
`ifdef KUYRUK_YUKLE_EN
    else if (yukle) begin
      rd <= '0;
      wr <= yukle_sayisi > TAM ? TAM : yukle_sayisi;
    end
`endif
    else begin
      if (yaz) wr <= wr + BIR;
      if (oku) rd <= rd + BIR;
    end
  end
  always_ff @(posedge clk) begin
`ifdef KUYRUK_YUKLE_EN
    if (yukle)
      for (int i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= yukle_veri[(DEPTH-i)*ENTRY_W-1 -: ENTRY_W];
    else
`endif
    if (yaz) mem[wr[ADDR_W-1:0]] <= yaz_veri;
  end
endmodule

// File: rtl/zamanli_kuyruk_denetleyicisi.sv
// zamanli_kuyruk_denetleyicisi: timed FIFO releasing each head entry after its cycle count expires
// Optional bulk-load ports (yukle, yukle_veri, yukle_sayisi) appear when KUYRUK_YUKLE_EN is defined.
module zamanli_kuyruk_denetleyicisi import kuyruk_pkg::*; #(
  parameter int DATA_W = 5,
  parameter int CNT_W = 3,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic islem_yap,
  input  logic giris_gecerli,
  output logic giris_hazir,
  input  logic [DATA_W-1:0] giris_veri,
  input  logic [CNT_W-1:0] giris_sayac,
  output logic cikan_gecerli,
  input  logic cikan_hazir,
  output logic [DATA_W-1:0] cikan_veri,
  output logic [CNT_W-1:0] cevrim_sayisi,
  output logic [$clog2(DEPTH):0] seviye,
  output logic dolu,
  output logic bos,
  output logic bitti
`ifdef KUYRUK_YUKLE_EN
  ,input logic yukle,
  input  logic [DEPTH*giris_w(CNT_W, DATA_W)-1:0] yukle_veri,
  input  logic [$clog2(DEPTH):0] yukle_sayisi
`endif
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ENTRY_W = giris_w(CNT_W, DATA_W);
  localparam int CNT_LSB = sayac_lsb(DATA_W);
  durum_t durum, durum_n;
  logic [CNT_W-1:0] sayac, sayac_n, sonraki_sayac;
  logic [DATA_W-1:0] bas_veri;
  logic yuk, yaz, oku, yukle_bos;
  logic [CNT_W-1:0] yukle_sayac;
  function automatic durum_t bas_durumu(input logic [CNT_W-1:0] c);
    return c == '0 ? HAZIR : SAYIYOR;
  endfunction
`ifdef KUYRUK_YUKLE_EN
  logic [ENTRY_W-1:0] yukle_bas;
  assign yuk = yukle;
  assign yukle_bas = yukle_veri[DEPTH*ENTRY_W-1 -: ENTRY_W];
  assign yukle_sayac = yukle_bas[CNT_LSB +: CNT_W];
  assign yukle_bos = yukle_sayisi == '0;
`else
  assign yuk = 1'b0;
  assign yukle_sayac = '0;
  assign yukle_bos = 1'b1;
`endif
  assign giris_hazir = !dolu;
  assign cikan_gecerli = durum == HAZIR;
  assign yaz = giris_gecerli && giris_hazir && !yuk;
  assign oku = cikan_gecerli && cikan_hazir && !yuk;
  assign cikan_veri = durum == BOS ? '0 : bas_veri;
  assign cevrim_sayisi = durum == SAYIYOR ? sayac : '0;
  kuyruk_bellek #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) u_bellek (
    .clk(clk), .rst(rst), .yaz(yaz), .oku(oku),
    .yaz_veri({giris_sayac, giris_veri}),
    .bas_veri(bas_veri), .sonraki_sayac(sonraki_sayac),
    .seviye(seviye), .dolu(dolu), .bos(bos)
`ifdef KUYRUK_YUKLE_EN
    ,.yukle(yukle), .yukle_veri(yukle_veri), .yukle_sayisi(yukle_sayisi)
`endif
  );
  always_comb begin
    durum_n = durum;
    sayac_n = sayac;
    if (yuk) begin
      sayac_n = yukle_sayac;
      durum_n = yukle_bos ? BOS : bas_durumu(yukle_sayac);
    end else if (durum == BOS && yaz) begin
      sayac_n = giris_sayac;
      durum_n = bas_durumu(giris_sayac);
    end else if (durum == SAYIYOR && islem_yap) begin
      sayac_n = sayac - CNT_W'(1);
      durum_n = sayac == CNT_W'(1) ? HAZIR : SAYIYOR;
    end else if (oku) begin
      // the last entry leaving while a push lands takes the pushed entry as the new head
      sayac_n = seviye > (ADDR_W+1)'(1) ? sonraki_sayac : yaz ? giris_sayac : '0;
      durum_n = seviye > (ADDR_W+1)'(1) || yaz ? bas_durumu(sayac_n) : BOS;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      durum <= BOS;
      sayac <= '0;
      bitti <= 1'b0;
    end else begin
      durum <= durum_n;
      sayac <= sayac_n;
      bitti <= oku;
    end
  end
endmodule

// File: tb/tb_zamanli_kuyruk_denetleyicisi.sv
// tb_zamanli_kuyruk_denetleyicisi: scoreboard bench for the timed queue; covers KUYRUK_YUKLE_EN when defined
module tb_zamanli_kuyruk_denetleyicisi;
  localparam int DATA_W = 5, CNT_W = 3, DEPTH = 8, ADDR_W = 3, ENTRY_W = 8;
  logic clk = 0, rst = 1, islem_yap = 0, giris_gecerli = 0, cikan_hazir = 0;
  logic giris_hazir, cikan_gecerli, dolu, bos, bitti;
  logic [DATA_W-1:0] giris_veri = '0, cikan_veri;
  logic [CNT_W-1:0] giris_sayac = '0, cevrim_sayisi;
  logic [ADDR_W:0] seviye;
  logic yukle_tb = 0;
  int hata = 0, kontrol = 0;
  logic [DATA_W-1:0] skor_q[$];
`ifdef KUYRUK_YUKLE_EN
  logic [DEPTH*ENTRY_W-1:0] yukle_veri = '0;
  logic [ADDR_W:0] yukle_sayisi = '0;
`endif
  always #5 clk = ~clk;
  zamanli_kuyruk_denetleyicisi #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .islem_yap(islem_yap),
    .giris_gecerli(giris_gecerli), .giris_hazir(giris_hazir),
    .giris_veri(giris_veri), .giris_sayac(giris_sayac),
    .cikan_gecerli(cikan_gecerli), .cikan_hazir(cikan_hazir),
    .cikan_veri(cikan_veri), .cevrim_sayisi(cevrim_sayisi),
    .seviye(seviye), .dolu(dolu), .bos(bos), .bitti(bitti)
`ifdef KUYRUK_YUKLE_EN
    ,.yukle(yukle_tb), .yukle_veri(yukle_veri), .yukle_sayisi(yukle_sayisi)
`endif
  );
  task automatic denetle(input string tag, input logic [31:0] gercek, input logic [31:0] beklenen);
    kontrol++;
    if (gercek !== beklenen) begin
      hata++;
      $display("FAIL %s: gercek=%0h beklenen=%0h", tag, gercek, beklenen);
    end
  endtask
  task automatic tik();
    @(posedge clk);
    #1;
  endtask
  task automatic it(input logic [CNT_W-1:0] c, input logic [DATA_W-1:0] d);
    giris_gecerli = 1;
    giris_sayac = c;
    giris_veri = d;
    tik();
    giris_gecerli = 0;
  endtask
  always @(negedge clk) begin
    if (!rst && !yukle_tb) begin
      if (giris_gecerli && giris_hazir) skor_q.push_back(giris_veri);
      if (cikan_gecerli && cikan_hazir) begin
        if (skor_q.size() == 0) denetle("skor_bos_cikis", cikan_veri, 32'hFFFF_FFFF);
        else denetle("skor_veri", cikan_veri, skor_q.pop_front());
      end
    end
  end
  initial begin
    tik();
    tik();
    rst = 0;
    tik();
    denetle("rst_gecerli", cikan_gecerli, 0);
    denetle("rst_veri", cikan_veri, 0);
    denetle("rst_sayi", cevrim_sayisi, 0);
    denetle("rst_seviye", seviye, 0);
    denetle("rst_bos_dolu_bitti_hazir", {bos, dolu, bitti, giris_hazir}, 4'b1001);
    islem_yap = 1;
    cikan_hazir = 1;
    it(3, 5'h15);
    denetle("t1_sayi3", {cikan_gecerli, cevrim_sayisi}, {1'b0, 3'd3});
    tik();
    denetle("t1_sayi2", {cikan_gecerli, cevrim_sayisi}, {1'b0, 3'd2});
    tik();
    denetle("t1_sayi1", {cikan_gecerli, cevrim_sayisi}, {1'b0, 3'd1});
    tik();
    denetle("t1_hazir", {cikan_gecerli, cevrim_sayisi, cikan_veri}, {1'b1, 3'd0, 5'h15});
    tik();
    denetle("t1_bitti", {bitti, bos, cikan_gecerli}, 3'b110);
    tik();
    denetle("t1_bitti_tek", bitti, 0);
    it(3, 5'h0A);
    tik();
    islem_yap = 0;
    for (int i = 0; i < 4; i++) begin
      tik();
      denetle("t2_donuk", {cikan_gecerli, cevrim_sayisi}, {1'b0, 3'd2});
    end
    islem_yap = 1;
    tik();
    denetle("t2_sayi1", {cikan_gecerli, cevrim_sayisi}, {1'b0, 3'd1});
    tik();
    denetle("t2_hazir", {cikan_gecerli, cikan_veri}, {1'b1, 5'h0A});
    tik();
    denetle("t2_bos", bos, 1);
    cikan_hazir = 0;
    for (int i = 1; i <= 8; i++) it(0, DATA_W'(i));
    denetle("t3_dolu", {dolu, giris_hazir, seviye}, {1'b1, 1'b0, 4'd8});
    it(0, 5'h09);
    denetle("t3_red", seviye, 8);
    giris_gecerli = 1;
    cikan_hazir = 1;
    tik();
    giris_gecerli = 0;
    denetle("t3_dolu_pop", {seviye, bitti}, {4'd7, 1'b1});
    for (int i = 0; i < 7; i++) begin
      tik();
      denetle("t3_bosalt", {seviye, bitti}, {4'(6 - i), 1'b1});
    end
    denetle("t3_bos", {bos, cikan_gecerli}, 2'b10);
    cikan_hazir = 0;
    it(0, 5'h11);
    denetle("t4_tek", {seviye, cikan_gecerli}, {4'd1, 1'b1});
    cikan_hazir = 1;
    it(0, 5'h12);
    denetle("t4_bypass", {seviye, cikan_gecerli, cikan_veri, bitti}, {4'd1, 1'b1, 5'h12, 1'b1});
    tik();
    denetle("t4_bos", bos, 1);
    cikan_hazir = 0;
    it(0, 5'h05);
    it(2, 5'h06);
    cikan_hazir = 1;
    tik();
    denetle("t5_sonraki", {cikan_gecerli, cevrim_sayisi}, {1'b0, 3'd2});
    tik();
    tik();
    denetle("t5_hazir", {cikan_gecerli, cikan_veri}, {1'b1, 5'h06});
    tik();
    cikan_hazir = 0;
    it(3, 5'h01);
    it(0, 5'h02);
    islem_yap = 0;
    it(0, 5'h03);
    it(0, 5'h04);
    denetle("t6_once", {seviye, cevrim_sayisi}, {4'd4, 3'd2});
    rst = 1;
    tik();
    skor_q.delete();
    denetle("t6_rst", {cikan_gecerli, cikan_veri, cevrim_sayisi, seviye, bos, dolu, bitti, giris_hazir},
            {1'b0, 5'h0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1});
    rst = 0;
    tik();
    denetle("t6_bitti_yok", bitti, 0);
`ifdef KUYRUK_YUKLE_EN
    islem_yap = 1;
    yukle_veri = {8'h1F, 8'h22, 8'h03, 40'h0};
    yukle_sayisi = 3;
    yukle_tb = 1;
    tik();
    yukle_tb = 0;
    skor_q = '{5'h1F, 5'h02, 5'h03};
    denetle("t7_yukle", {cikan_gecerli, cikan_veri, seviye}, {1'b1, 5'h1F, 4'd3});
    cikan_hazir = 1;
    for (int i = 0; i < 6; i++) tik();
    denetle("t7_bos", bos, 1);
`endif
    denetle("skor_kalan", skor_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", hata, kontrol);
    $finish;
  end
endmodule
